debouncer_multi: RTL and testbench

Parametrised N-channel successor to the single-button debouncer/edge detector. Each channel synchronises a raw button input and debounces it with a cycle counter. Each channel emits one-cycle press, release and long-press pulses, plus optional auto-repeat of the press pulse while the button is held. It sits between board button/switch pins and control FSMs; all outputs are in the clk domain.

---
 rtl/debouncer_multi_pkg.sv | 17 +
 rtl/debouncer_multi_if.sv | 11 +
 rtl/debouncer_multi_channel.sv | 104 ++++++++++
 rtl/debouncer_multi.sv | 45 ++++
 tb/tb_debouncer_multi.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/debouncer_multi_pkg.sv
// debouncer_multi_pkg: shared hold-FSM encodings and ms-to-cycle sizing helpers.
package debouncer_multi_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HELD     = 2'd1,
    REPEAT   = 2'd2,
    LONGHELD = 2'd3
  } hold_state_e;

  function automatic longint unsigned ms_to_cyc(input longint unsigned hz, input longint unsigned ms);
    return hz / 1000 * ms;
  endfunction

  function automatic int cnt_w(input longint unsigned x);
    return (x == 0) ? 1 : $clog2(x + 1);
  endfunction
endpackage

// File: rtl/debouncer_multi_if.sv
// debouncer_multi_if: button pins in, debounced levels and event pulses out.
interface debouncer_multi_if #(parameter int N_CH = 4);
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;
  logic            any_pressed;
  modport master (output btn_in, input btn_level, press_pulse, release_pulse, long_pulse, any_pressed);
  modport slave (input btn_in, output btn_level, press_pulse, release_pulse, long_pulse, any_pressed);
endinterface

// File: rtl/debouncer_multi_channel.sv
// debouncer_multi_channel: one button -- synchroniser, debounce counter and hold FSM.
module debouncer_multi_channel
  import debouncer_multi_pkg::*;
#(
  parameter longint unsigned DB_CYC   = 1000,
  parameter longint unsigned LONG_CYC = 0,
  parameter longint unsigned REP_CYC  = 0,
  parameter bit              INVERT   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);
  localparam int DW = cnt_w(DB_CYC);
  localparam int HW = cnt_w(LONG_CYC);
  localparam int RW = cnt_w(REP_CYC);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYC - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYC - 1);
  localparam bit LONG_EN = LONG_CYC != 0;
  localparam bit REP_EN  = LONG_EN && REP_CYC != 0;

  logic [1:0]    sync_q;
  logic          s, flip, accept, acc_press, acc_rel;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d, rel_q, rel_d, long_q, long_d;
  hold_state_e   state_q, state_d;

  assign s         = sync_q[1] ^ INVERT;
  assign flip      = s != level_q;
  assign accept    = flip && db_cnt_q == DB_LAST;
  assign acc_press = accept && s;
  assign acc_rel   = accept && !s;
  assign db_cnt_d  = (!flip || accept) ? '0 : db_cnt_q + 1'b1;
  assign level_d   = accept ? s : level_q;

  // An accepted level change overrides any long/repeat tick in the same cycle.
  always_comb begin
    state_d = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d = rep_cnt_q;
    press_d = acc_press;
    rel_d = acc_rel;
    long_d = 1'b0;
    if (accept) begin
      state_d = s ? HELD : IDLE;
      hold_cnt_d = '0;
      rep_cnt_d = '0;
    end else begin
      case (state_q)
        HELD: begin
          if (LONG_EN && hold_cnt_q == LONG_LAST) begin
            long_d = 1'b1;
            state_d = REP_EN ? REPEAT : LONGHELD;
          end else if (hold_cnt_q != '1) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          press_d = rep_cnt_q == REP_LAST;
          rep_cnt_d = press_d ? '0 : rep_cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sync flops idle at the released pin level so active-low pins see no edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{INVERT}};
      db_cnt_q <= '0;
      hold_cnt_q <= '0;
      rep_cnt_q <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
      long_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      db_cnt_q <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q <= rel_d;
      long_q <= long_d;
      state_q <= state_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;
endmodule

// File: rtl/debouncer_multi.sv
// debouncer_multi: N independent debounced button channels with press/release/long/repeat pulses.
module debouncer_multi
  import debouncer_multi_pkg::*;
#(
  parameter int              N_CH        = 4,
  parameter longint unsigned CLK_HZ      = 125000000,
  parameter longint unsigned DEBOUNCE_MS = 10,
  parameter longint unsigned LONG_MS     = 1000,
  parameter longint unsigned REPEAT_MS   = 0,
  parameter logic [N_CH-1:0] INVERT_MASK = '0
) (
  input logic              clk,
  input logic              rst_n,
  debouncer_multi_if.slave bus
);
  localparam longint unsigned DB_RAW   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam longint unsigned DB_CYC   = (DB_RAW == 0) ? 1 : DB_RAW;
  localparam longint unsigned LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);
  localparam longint unsigned REP_CYC  = ms_to_cyc(CLK_HZ, REPEAT_MS);

  logic [N_CH-1:0] level_w, press_w, rel_w, long_w;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    debouncer_multi_channel #(
      .DB_CYC(DB_CYC),
      .LONG_CYC(LONG_CYC),
      .REP_CYC(REP_CYC),
      .INVERT(INVERT_MASK[c])
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .btn_i(bus.btn_in[c]),
      .level_o(level_w[c]),
      .press_o(press_w[c]),
      .release_o(rel_w[c]),
      .long_o(long_w[c])
    );
  end

  assign bus.btn_level     = level_w;
  assign bus.press_pulse   = press_w;
  assign bus.release_pulse = rel_w;
  assign bus.long_pulse    = long_w;
  assign bus.any_pressed   = |level_w;
endmodule

// File: tb/tb_debouncer_multi.sv
// tb_debouncer_multi: run-length stimulus, event-time scoreboard for a no-repeat and a repeat instance.
module tb_debouncer_multi;
  localparam int N  = 4;
  localparam int DB = 1000;
  localparam int LC = 3000;
  localparam int RC = 1000;
  localparam logic [N-1:0] INV = 4'b1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] lvl = '0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  int exp_q [2][N][3][$];
  int lv_t [N][$];
  bit lv_v [N][$];
  bit rv [N][$];
  int rl [N][$];
  logic [N-1:0] mlev = '0;
  logic [N-1:0] plv [2];
  string kn [3] = '{"press", "release", "long"};

  debouncer_multi_if #(.N_CH(N)) if0 ();
  debouncer_multi_if #(.N_CH(N)) if1 ();
  assign if0.btn_in = lvl ^ INV;
  assign if1.btn_in = lvl ^ INV;

  debouncer_multi #(.N_CH(N), .CLK_HZ(1000000), .DEBOUNCE_MS(1), .LONG_MS(3), .REPEAT_MS(0),
                    .INVERT_MASK(INV)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  debouncer_multi #(.N_CH(N), .CLK_HZ(1000000), .DEBOUNCE_MS(1), .LONG_MS(3), .REPEAT_MS(1),
                    .INVERT_MASK(INV)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic [N-1:0] pl [2][3];
  logic [N-1:0] lv [2];
  logic ap [2];
  assign pl[0][0] = if0.press_pulse;
  assign pl[0][1] = if0.release_pulse;
  assign pl[0][2] = if0.long_pulse;
  assign pl[1][0] = if1.press_pulse;
  assign pl[1][1] = if1.release_pulse;
  assign pl[1][2] = if1.long_pulse;
  assign lv[0] = if0.btn_level;
  assign lv[1] = if1.btn_level;
  assign ap[0] = if0.any_pressed;
  assign ap[1] = if1.any_pressed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events of one accepted press at p and release at r, for both instances.
  task automatic add_hold(input int c, input int p, input int r);
    for (int d = 0; d < 2; d++) begin
      int l = p + LC;
      exp_q[d][c][0].push_back(p);
      if (l < r) begin
        exp_q[d][c][2].push_back(l);
        if (d == 1)
          for (int t = l + RC; t < r; t += RC) exp_q[d][c][0].push_back(t);
      end
      exp_q[d][c][1].push_back(r);
    end
    lv_t[c].push_back(p); lv_v[c].push_back(1'b1);
    lv_t[c].push_back(r); lv_v[c].push_back(1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      bit chg = 1'b0;
      for (int c = 0; c < N; c++)
        while (lv_t[c].size() > 0 && lv_t[c][0] <= cyc) begin
          mlev[c] = lv_v[c][0];
          void'(lv_t[c].pop_front());
          void'(lv_v[c].pop_front());
          chg = 1'b1;
        end
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < N; c++)
          for (int k = 0; k < 3; k++) begin
            string nm = $sformatf("dut%0d ch%0d %s time", d, c, kn[k]);
            if (exp_q[d][c][k].size() > 0 && exp_q[d][c][k][0] < cyc) begin
              tests++;
              fails++;
              $display("FAIL %s: got no pulse, expected one at cycle %0d", nm, exp_q[d][c][k].pop_front());
            end
            if (pl[d][k][c]) begin
              if (exp_q[d][c][k].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL %s: got unexpected pulse at cycle %0d, expected none", nm, cyc);
              end else chk(nm, cyc, exp_q[d][c][k].pop_front());
            end
          end
        if (chg || lv[d] != plv[d]) begin
          chk($sformatf("dut%0d btn_level", d), int'(lv[d]), int'(mlev));
          chk($sformatf("dut%0d any_pressed", d), int'(ap[d]), int'(|mlev));
        end
        plv[d] = lv[d];
      end
    end
  end

  task automatic chk_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d btn_level", tag, d), int'(lv[d]), 0);
      chk($sformatf("%s dut%0d press", tag, d), int'(pl[d][0]), 0);
      chk($sformatf("%s dut%0d release", tag, d), int'(pl[d][1]), 0);
      chk($sformatf("%s dut%0d long", tag, d), int'(pl[d][2]), 0);
      chk($sformatf("%s dut%0d any_pressed", tag, d), int'(ap[d]), 0);
    end
  endtask

  // Applies the queued runs from now, padding every channel with a final released run.
  task automatic run_phase();
    int s = cyc;
    int tot = 0;
    int sum [N];
    int idx [N];
    int rem [N];
    for (int c = 0; c < N; c++) begin
      sum[c] = 0;
      foreach (rl[c][i]) sum[c] += rl[c][i];
      if (sum[c] > tot) tot = sum[c];
    end
    tot += 1100;
    for (int c = 0; c < N; c++) begin
      bit lev = 1'b0;
      int st = s;
      int p = 0;
      rv[c].push_back(1'b0);
      rl[c].push_back(tot - sum[c]);
      foreach (rv[c][i]) begin
        if (rv[c][i] != lev && rl[c][i] >= DB) begin
          lev = rv[c][i];
          if (lev) p = st + DB + 2;
          else add_hold(c, p, st + DB + 2);
        end
        st += rl[c][i];
      end
      idx[c] = 0;
      rem[c] = 0;
    end
    for (int t = 0; t < tot; t++) begin
      for (int c = 0; c < N; c++) begin
        if (rem[c] == 0) begin
          lvl[c] = rv[c][idx[c]];
          rem[c] = rl[c][idx[c]];
          idx[c]++;
        end
        rem[c]--;
      end
      @(posedge clk); #1;
    end
    for (int c = 0; c < N; c++) begin
      rv[c].delete();
      rl[c].delete();
    end
  endtask

  task automatic add_run(input int c, input bit v, input int len);
    rv[c].push_back(v);
    rl[c].push_back(len);
  endtask

  initial begin
    int k;
    plv[0] = '0;
    plv[1] = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("in_reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    // Directed: bouncy press/short hold, long hold, glitch then threshold pulse, active-low pin.
    add_run(0, 1, 20); add_run(0, 0, 10); add_run(0, 1, 40); add_run(0, 0, 15); add_run(0, 1, 1500);
    add_run(1, 1, 5000);
    add_run(2, 1, 999); add_run(2, 0, 1200); add_run(2, 1, 1000);
    add_run(3, 0, 200); add_run(3, 1, 2000);
    run_phase();
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < N; c++)
        for (int i = 0; i < 7; i++) begin
          int r = int'($urandom_range(0, 9));
          add_run(c, i % 2 == 0, r < 4 ? int'($urandom_range(1, 60)) :
                                 r < 6 ? int'($urandom_range(995, 1005)) : int'($urandom_range(1000, 4200)));
        end
      run_phase();
    end
    // Reset while ch0 is held: outputs clear at once and the held pin is re-accepted afterwards.
    lvl[0] = 1'b1;
    for (int d = 0; d < 2; d++) exp_q[d][0][0].push_back(cyc + DB + 2);
    lv_t[0].push_back(cyc + DB + 2); lv_v[0].push_back(1'b1);
    repeat (1500) @(posedge clk);
    #3 rst_n = 1'b0;
    mon_en = 1'b0;
    #1 chk_zero("reset_mid_hold");
    for (int c = 0; c < N; c++) begin
      for (int d = 0; d < 2; d++)
        for (int j = 0; j < 3; j++) exp_q[d][c][j].delete();
      lv_t[c].delete();
      lv_v[c].delete();
      lv_t[c].push_back(cyc); lv_v[c].push_back(1'b0);
    end
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    k = cyc;
    add_hold(0, k + DB + 2, k + 2000 + DB + 2);
    mon_en = 1'b1;
    repeat (2000) @(posedge clk);
    #1 lvl[0] = 1'b0;
    repeat (1200) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++)
        for (int j = 0; j < 3; j++) begin
          tests++;
          if (exp_q[d][c][j].size() != 0) begin
            fails++;
            $display("FAIL dut%0d ch%0d %s leftover: got %0d pending, expected 0", d, c, kn[j], exp_q[d][c][j].size());
          end
        end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
